sudoku_group_checker: RTL and testbench
=======================================

Name: sudoku_group_checker

Overview:
- Sequencer that walks all 27 Sudoku constraint groups (9 rows, 9 columns, 9 boxes) of an 81-cell board held in external cell storage.
- For each group: fetches 9 cell values over a read port, presents them to an internal values2onehot instance, and decides whether the group has a duplicate or illegal value and whether it is complete.
- Sits between board storage and the solver's top-level control. It answers "is the board consistent?" and "is the board solved?" after each solver step.

Parameters:
- RD_LAT, 1, read-port latency in cycles from rd_en/rd_addr to valid rd_data; legal values 1..3.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin full-board check; sampled only in IDLE
- abort  in  1  synchronous; returns to IDLE next cycle, no done pulse
- rd_en  out  1  cell read strobe
- rd_addr  out  7  cell index 0..80, row-major (row*9+col)
- rd_data  in  4  cell value, RD_LAT cycles after rd_en; 0 = empty, 1..9 = digit
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of check
- conflict  out  1  sticky; a group contained a duplicate or illegal value; cleared on accepted start
- conflict_group  out  5  index (0..26) of first conflicting group; valid when conflict=1
- complete  out  1  registered with done; 1 iff no conflict and all 27 groups have all 9 digits

Behaviour:
- Reset values: all outputs 0; state IDLE; value buffer cleared.
- Group order: g=0..8 are rows r=g; g=9..17 are columns c=g-9; g=18..26 are boxes b=g-18.
- Element k=0..8 address:
  - row: r*9+k
  - column: k*9+c
  - box: (3*(b/3)+k/3)*9 + 3*(b%3)+k%3
- States: IDLE -> FETCH -> DRAIN -> EVAL -> (FETCH for next group | DONE) -> IDLE.
- FETCH: 9 cycles, rd_en=1, one address per cycle, k=0..8.
- DRAIN: RD_LAT cycles, rd_en=0.
- Capture: rd_data captured into buffer slot k exactly RD_LAT cycles after the issue of address k.
- EVAL: 1 cycle. Feeds the buffer to values2onehot.
  - Group is bad if any value is in 10..15, or if the number of nonzero values exceeds popcount(onehot).
  - Group is full if onehot == 9'h1FF.
  - On the first bad group: set conflict and latch g into conflict_group. Later bad groups do not overwrite conflict_group.
- DONE: 1 cycle. done=1; complete = all_full & ~conflict; busy drops in the same cycle.
- Latency: start accepted at cycle 0; group g occupies cycles g*(10+RD_LAT)+1 .. (g+1)*(10+RD_LAT); done occurs at cycle 27*(10+RD_LAT)+1. With RD_LAT=1, done occurs at cycle 298.
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins, stays IDLE.
- abort mid-check: returns to IDLE next cycle. rd_en=0, busy=0, no done. conflict and complete keep their pre-start-cleared values, i.e. 0.
- Async rst mid-check: immediate return to reset values; in-flight read data ignored.
- Board contents are assumed static while busy; the checker does not detect mid-check writes.

Optional Feature:
- Macro: GROUP_CHECKER_EARLY_ABORT_EN.
- Defined: on the first bad group the EVAL state goes directly to DONE. done asserts the cycle after that EVAL; complete=0; remaining groups are not read.
- Undefined: all 27 groups are always scanned, and done timing is fixed as above regardless of contents.

Test Plan:
- Valid solved grid (e.g. canonical cell = ((r*3 + r/3 + c) % 9) + 1), RD_LAT=1, start -> done at cycle 298, conflict=0, complete=1, exactly 243 rd_en cycles.
- Same grid with cell 40 set to 0 -> done at cycle 298, conflict=0, complete=0.
- Solved grid with cells 0 and 1 both =5 (row 0 duplicate) -> conflict=1, conflict_group=0, complete=0. With GROUP_CHECKER_EARLY_ABORT_EN: done at cycle 12.
- Grid with only box 8 duplicate (cells 60 and 80 both =3, col and row unique) -> conflict_group=26. With RD_LAT=3: done at cycle 352.
- Cell 17 = 12 (illegal), rest empty -> conflict=1, conflict_group=1.
- abort at cycle 50, then start at cycle 55 -> no done from the first run; second run's done at cycle 55+298. rst pulse at cycle 100 -> all outputs 0 immediately.

Source files
------------

// File: rtl/sudoku_group_checker_if.sv
// Bundles the checker's control/status handshake and board read port.
// slave = checker side, master = solver control plus cell storage side.
interface sudoku_group_checker_if;
   logic       start;
   logic       abort;
   logic       rd_en;
   logic [6:0] rd_addr;
   logic [3:0] rd_data;
   logic       busy;
   logic       done;
   logic       conflict;
   logic [4:0] conflict_group;
   logic       complete;

   modport master (
      output start, abort, rd_data,
      input  rd_en, rd_addr, busy, done, conflict, conflict_group, complete
   );

   modport slave (
      input  start, abort, rd_data,
      output rd_en, rd_addr, busy, done, conflict, conflict_group, complete
   );
endinterface

// File: rtl/sudoku_group_checker.sv
// Walks all 27 Sudoku groups (rows, columns, boxes) and reports conflict/completion.
// Optional macro GROUP_CHECKER_EARLY_ABORT_EN: finish right after the first bad group.
module values2onehot (
   input  logic [8:0][3:0] vals,
   output logic [8:0]      onehot
);
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < 9; i++) begin
         if (vals[4'(i)] >= 4'd1 && vals[4'(i)] <= 4'd9) onehot[vals[4'(i)] - 4'd1] = 1'b1;
      end
   end
endmodule

module sudoku_group_checker #(
   parameter int unsigned RD_LAT = 1
) (
   input logic                  clk,
   input logic                  rst,
   sudoku_group_checker_if.slave bus
);
`ifdef GROUP_CHECKER_EARLY_ABORT_EN
   localparam bit EARLY_ABORT = 1'b1;
`else
   localparam bit EARLY_ABORT = 1'b0;
`endif
   localparam logic [1:0] DRAIN_INIT = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EVAL, DONE} state_t;

   state_t                     state_q, state_d;
   logic [4:0]                 g_q, g_d;
   logic [3:0]                 k_q, k_d;
   logic [1:0]                 drain_q, drain_d;
   logic                       rd_en_q, rd_en_d;
   logic [6:0]                 rd_addr_q, rd_addr_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       conflict_q, conflict_d;
   logic [4:0]                 cgroup_q, cgroup_d;
   logic                       complete_q, complete_d;
   logic                       all_full_q, all_full_d;
   logic [8:0][3:0]            buf_q, buf_d;
   logic [RD_LAT-1:0]          pipe_v_q, pipe_v_d;
   logic [RD_LAT-1:0][3:0]     pipe_k_q, pipe_k_d;

   logic [8:0] onehot;
   logic [3:0] nz_cnt, oh_cnt;
   logic       illegal, grp_bad, grp_full;

   function automatic logic [6:0] cell_addr(input logic [4:0] g, input logic [3:0] k);
      int unsigned gi, ki, b, r, c;
      gi = {27'd0, g};
      ki = {28'd0, k};
      b  = 0;
      if (gi < 9) begin
         r = gi;
         c = ki;
      end else if (gi < 18) begin
         r = ki;
         c = gi - 9;
      end else begin
         b = gi - 18;
         r = 3 * (b / 3) + ki / 3;
         c = 3 * (b % 3) + ki % 3;
      end
      return 7'(r * 9 + c);
   endfunction

   values2onehot u_v2oh (
      .vals   (buf_q),
      .onehot (onehot)
   );

   // Nonzero entries beyond the distinct-digit count means a repeat or an out-of-range value.
   always_comb begin
      nz_cnt  = '0;
      oh_cnt  = '0;
      illegal = 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
         if (buf_q[4'(i)] != 4'd0) nz_cnt = nz_cnt + 4'd1;
         if (buf_q[4'(i)] > 4'd9) illegal = 1'b1;
         oh_cnt = oh_cnt + {3'd0, onehot[4'(i)]};
      end
      grp_bad  = illegal | (nz_cnt > oh_cnt);
      grp_full = (onehot == 9'h1FF);
   end

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      k_d        = k_q;
      drain_d    = drain_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      conflict_d = conflict_q;
      cgroup_d   = cgroup_q;
      complete_d = complete_q;
      all_full_d = all_full_q;
      buf_d      = buf_q;
      // Slot tags travel alongside the read so data lands exactly RD_LAT cycles after issue.
      pipe_v_d   = RD_LAT'({pipe_v_q, rd_en_q});
      pipe_k_d   = (RD_LAT * 4)'({pipe_k_q, k_q});

      if (pipe_v_q[RD_LAT-1]) buf_d[pipe_k_q[RD_LAT-1]] = bus.rd_data;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d    = FETCH;
               g_d        = '0;
               k_d        = '0;
               rd_en_d    = 1'b1;
               rd_addr_d  = '0;
               busy_d     = 1'b1;
               conflict_d = 1'b0;
               cgroup_d   = '0;
               complete_d = 1'b0;
               all_full_d = 1'b1;
            end
         end
         FETCH: begin
            if (k_q == 4'd8) begin
               state_d = DRAIN;
               drain_d = DRAIN_INIT;
            end else begin
               k_d       = k_q + 4'd1;
               rd_en_d   = 1'b1;
               rd_addr_d = cell_addr(g_q, k_q + 4'd1);
            end
         end
         DRAIN: begin
            if (drain_q == 2'd0) state_d = EVAL;
            else drain_d = drain_q - 2'd1;
         end
         EVAL: begin
            conflict_d = conflict_q | grp_bad;
            if (grp_bad && !conflict_q) cgroup_d = g_q;
            all_full_d = all_full_q & grp_full;
            if (g_q == 5'd26 || (EARLY_ABORT && grp_bad)) begin
               state_d    = DONE;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               complete_d = all_full_q & grp_full & ~(conflict_q | grp_bad);
            end else begin
               state_d   = FETCH;
               g_d       = g_q + 5'd1;
               k_d       = '0;
               rd_en_d   = 1'b1;
               rd_addr_d = cell_addr(g_q + 5'd1, 4'd0);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (bus.abort && state_q != IDLE) begin
         state_d    = IDLE;
         rd_en_d    = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         conflict_d = 1'b0;
         cgroup_d   = '0;
         complete_d = 1'b0;
         pipe_v_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         g_q        <= '0;
         k_q        <= '0;
         drain_q    <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         conflict_q <= 1'b0;
         cgroup_q   <= '0;
         complete_q <= 1'b0;
         all_full_q <= 1'b0;
         buf_q      <= '0;
         pipe_v_q   <= '0;
         pipe_k_q   <= '0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         k_q        <= k_d;
         drain_q    <= drain_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         conflict_q <= conflict_d;
         cgroup_q   <= cgroup_d;
         complete_q <= complete_d;
         all_full_q <= all_full_d;
         buf_q      <= buf_d;
         pipe_v_q   <= pipe_v_d;
         pipe_k_q   <= pipe_k_d;
      end
   end

   assign bus.rd_en          = rd_en_q;
   assign bus.rd_addr        = rd_addr_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.conflict       = conflict_q;
   assign bus.conflict_group = cgroup_q;
   assign bus.complete       = complete_q;
endmodule

// File: tb/tb_sudoku_group_checker.sv
// Scoreboard bench for sudoku_group_checker: a set-based board model feeds expected
// addresses and results into queues; a negedge monitor pops and compares.
module tb_sudoku_group_checker;
   localparam int unsigned RD_LAT = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   sudoku_group_checker_if bus ();

   sudoku_group_checker #(.RD_LAT(RD_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit conflict;
      int group;
      bit complete;
      int reads;
   } exp_t;

   exp_t exp_q[$];
   int   exp_addr[$];
   exp_t last_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   rd_cnt = 0;

   logic [3:0]        mem [81];
   bit   [RD_LAT-1:0] pv = '0;
   logic [6:0]        pa [RD_LAT];

   // Cell storage with RD_LAT cycles of read latency.
   always @(posedge clk) begin
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
      pv[0] <= bus.rd_en;
      pa[0] <= bus.rd_addr;
   end
   assign bus.rd_data = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : 4'h0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (bus.rd_en === 1'b1) begin
            rd_cnt++;
            if (exp_addr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read: got addr %0d, expected no read", bus.rd_addr);
            end else begin
               chk("rd_addr", bus.rd_addr, exp_addr.pop_front());
            end
         end
         if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc - start_cyc + 1);
            end else begin
               e = exp_q.pop_front();
               chk("done_cycle", cyc - start_cyc + 1, e.cyc);
               chk("conflict", bus.conflict, e.conflict);
               if (e.conflict) chk("conflict_group", bus.conflict_group, e.group);
               chk("complete", bus.complete, e.complete);
               chk("read_count", rd_cnt, e.reads);
               chk("busy_at_done", bus.busy, 0);
            end
         end
      end
   end

   // Reference: groups are the sets of cells sharing a row, column or box, in ascending index order.
   task automatic load_model(input bit push_exp);
      int   first = -1;
      bit   all_full = 1'b1;
      int   scanned = 0;
      exp_t e;
      for (int g = 0; g < 27; g++) begin
         int cnt[16];
         bit bad;
         bit full;
         foreach (cnt[v]) cnt[v] = 0;
         for (int idx = 0; idx < 81; idx++) begin
            int r, c, b;
            r = idx / 9;
            c = idx % 9;
            b = (r / 3) * 3 + c / 3;
            if ((g < 9 && r == g) || (g >= 9 && g < 18 && c == g - 9) || (g >= 18 && b == g - 18)) begin
               exp_addr.push_back(idx);
               cnt[mem[idx]]++;
            end
         end
         bad  = 1'b0;
         full = 1'b1;
         for (int v = 10; v < 16; v++) if (cnt[v] != 0) bad = 1'b1;
         for (int v = 1; v < 10; v++) begin
            if (cnt[v] > 1) bad = 1'b1;
            if (cnt[v] != 1) full = 1'b0;
         end
         scanned++;
         all_full = all_full & full;
         if (bad && first < 0) first = g;
`ifdef GROUP_CHECKER_EARLY_ABORT_EN
         if (bad) break;
`endif
      end
      e.cyc      = scanned * (10 + int'(RD_LAT)) + 1;
      e.conflict = (first >= 0);
      e.group    = first;
      e.complete = all_full && (first < 0);
      e.reads    = 9 * scanned;
      if (push_exp) begin
         exp_q.push_back(e);
         last_e = e;
      end
   endtask

   task automatic set_empty();
      for (int i = 0; i < 81; i++) mem[i] = 4'd0;
   endtask

   task automatic set_canon();
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            mem[r*9+c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
   endtask

   task automatic set_random();
      int p[9];
      int n;
      for (int i = 0; i < 9; i++) p[i] = i + 1;
      for (int i = 8; i > 0; i--) begin
         int j, t;
         j    = int'($urandom_range(i, 0));
         t    = p[i];
         p[i] = p[j];
         p[j] = t;
      end
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++)
            mem[r*9+c] = 4'(p[(r * 3 + r / 3 + c) % 9]);
      n = int'($urandom_range(3, 0));
      repeat (n) mem[$urandom_range(80, 0)] = 4'($urandom_range(15, 0));
   endtask

   // Caller is at a negedge; start is sampled at the next posedge (cycle 0).
   task automatic do_start();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      start_cyc = cyc;
      rd_cnt    = 0;
   endtask

   task automatic wait_done(input bit poke);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         bus.start = (poke && i == 20);
      end
      bus.start = 1'b0;
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      chk("reads_left", exp_addr.size(), 0);
      exp_addr.delete();
      chk("busy_idle", bus.busy, 0);
      chk("rd_en_idle", bus.rd_en, 0);
      chk("conflict_hold", bus.conflict, last_e.conflict);
      chk("complete_hold", bus.complete, last_e.complete);
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_rd_en"}, bus.rd_en, 0);
      chk({tag, "_rd_addr"}, bus.rd_addr, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_conflict"}, bus.conflict, 0);
      chk({tag, "_conflict_group"}, bus.conflict_group, 0);
      chk({tag, "_complete"}, bus.complete, 0);
   endtask

   initial begin
      int first_start;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_empty();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      set_canon();
      load_model(1); do_start(); wait_done(0);

      set_canon(); mem[40] = 4'd0;
      load_model(1); do_start(); wait_done(0);

      set_canon(); mem[0] = 4'd5; mem[1] = 4'd5;
      load_model(1); do_start(); wait_done(0);

      set_empty(); mem[60] = 4'd3; mem[80] = 4'd3;
      load_model(1); do_start(); wait_done(0);

      set_empty(); mem[17] = 4'd12;
      load_model(1); do_start(); wait_done(0);

      for (int t = 0; t < 6; t++) begin
         set_random();
         load_model(1); do_start(); wait_done(t == 0);
      end

      // Abort mid-check, then restart a few cycles later.
      set_canon();
      load_model(0);
      do_start();
      first_start = start_cyc;
      while (cyc - start_cyc + 1 < 50) @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      exp_addr.delete();
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_rd_en", bus.rd_en, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_conflict", bus.conflict, 0);
      chk("abort_complete", bus.complete, 0);
      while (cyc - first_start + 1 < 55) @(negedge clk);
      load_model(1); do_start(); wait_done(0);
      chk("restart_offset", start_cyc - first_start, 55);

      // start and abort together in IDLE: abort wins.
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);
      chk("start_abort_busy", bus.busy, 0);
      chk("start_abort_rd_en", bus.rd_en, 0);
      repeat (5) @(negedge clk);

      // Asynchronous reset mid-check.
      set_canon(); mem[0] = 4'd5; mem[1] = 4'd5;
      load_model(1);
      do_start();
      while (cyc - start_cyc + 1 < 100) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      exp_q.delete();
      exp_addr.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      set_canon();
      load_model(1); do_start(); wait_done(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
